fb_arbiter: RTL and testbench

Shares the single-port framebuffer memory between the display fetch path and a host pixel-write port, all in the `pixel_clk` domain. Display reads have strict priority. They are issued as fixed-length bursts whenever the display FIFO reports room, and the read address is re-aligned to pixel 0 on each frame start. Host writes are single-word and are served only when display reads are idle. The block sits between the framebuffer memory (Avalon-MM master side) and the display FIFO that feeds the video timing generator.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_arbiter_if.sv | 30 +++
 rtl/fb_arbiter.sv | 146 ++++++++++++++
 tb/tb_fb_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer arbiter: FSM state encoding,
// pixel word width and the pixel-index to byte-address mapping.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_CMD  = 2'd3
    } fb_state_t;

    localparam int PIX_W = 32;

    // One 32-bit pixel per memory word, so the byte address is base + 4*index.
    function automatic logic [63:0] fb_byte_addr(input logic [63:0] base, input logic [63:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Avalon-MM style memory port between the arbiter (master) and the framebuffer memory (slave).
// Handshake: a command (mem_read or mem_write) is accepted on the rising edge where it is high
// and mem_waitrequest is low; until then every command field is held stable. Read beats return
// later, one per edge where mem_readdatavalid is high, with no back-pressure.
interface fb_arbiter_if
    import fb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int BCW = 5
);
    logic [AW-1:0]    mem_address;
    logic             mem_read;
    logic             mem_write;
    logic [BCW-1:0]   mem_burstcount;
    logic [PIX_W-1:0] mem_writedata;
    logic [PIX_W-1:0] mem_readdata;
    logic             mem_readdatavalid;
    logic             mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_burstcount, mem_writedata,
        input  mem_readdata, mem_readdatavalid, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_burstcount, mem_writedata,
        output mem_readdata, mem_readdatavalid, mem_waitrequest
    );

endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display read bursts have strict priority over
// single-word host writes; a frame start re-aligns the read pointer to pixel 0.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int             HDISP = 800,
    parameter int             VDISP = 480,
    parameter int             BURST = 16,
    parameter int             AW    = 32,
    parameter logic [AW-1:0]  BASE  = '0
)(
    input  logic                             pixel_clk,
    input  logic                             pixel_rst,
    input  logic                             frame_start,
    input  logic                             fifo_low,
    output logic [PIX_W-1:0]                 pix_data,
    output logic                             pix_valid,
    input  logic                             wr_valid,
    input  logic [$clog2(HDISP*VDISP)-1:0]   wr_addr,
    input  logic [PIX_W-1:0]                 wr_data,
    output logic                             wr_ready,
    output fb_state_t                        dbg_state,
    fb_arbiter_if.master                     mem
);

    localparam int NPIX = HDISP * VDISP;
    localparam int IW   = $clog2(NPIX);
    localparam int BCW  = $clog2(BURST) + 1;

    fb_state_t        state, state_n;
    logic [IW-1:0]    rd_ptr, rd_ptr_n;
    logic             restart, restart_n;
    logic [BCW-1:0]   beat_cnt, beat_cnt_n;

    logic [PIX_W-1:0] pix_data_n;
    logic             pix_valid_n;
    logic             wr_ready_n;
    logic [AW-1:0]    addr_n;
    logic             read_n;
    logic             write_n;
    logic [BCW-1:0]   burst_n;
    logic [PIX_W-1:0] wdata_n;

    assign dbg_state = state;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state              <= IDLE;
            rd_ptr             <= '0;
            restart            <= 1'b0;
            beat_cnt           <= '0;
            pix_data           <= '0;
            pix_valid          <= 1'b0;
            wr_ready           <= 1'b0;
            mem.mem_address    <= '0;
            mem.mem_read       <= 1'b0;
            mem.mem_write      <= 1'b0;
            mem.mem_burstcount <= '0;
            mem.mem_writedata  <= '0;
        end else begin
            state              <= state_n;
            rd_ptr             <= rd_ptr_n;
            restart            <= restart_n;
            beat_cnt           <= beat_cnt_n;
            pix_data           <= pix_data_n;
            pix_valid          <= pix_valid_n;
            wr_ready           <= wr_ready_n;
            mem.mem_address    <= addr_n;
            mem.mem_read       <= read_n;
            mem.mem_write      <= write_n;
            mem.mem_burstcount <= burst_n;
            mem.mem_writedata  <= wdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        rd_ptr_n    = rd_ptr;
        restart_n   = restart | frame_start;
        beat_cnt_n  = beat_cnt;
        pix_data_n  = pix_data;
        pix_valid_n = 1'b0;
        wr_ready_n  = 1'b0;
        addr_n      = mem.mem_address;
        read_n      = mem.mem_read;
        write_n     = mem.mem_write;
        burst_n     = mem.mem_burstcount;
        wdata_n     = mem.mem_writedata;

        case (state)
            IDLE: begin
                // A pending restart re-aligns the pointer before any read is issued.
                if (restart) begin
                    rd_ptr_n  = '0;
                    restart_n = frame_start;
                end
                if (fifo_low) begin
                    state_n = RD_CMD;
                    read_n  = 1'b1;
                    burst_n = BCW'(BURST);
                    addr_n  = AW'(fb_byte_addr(64'(BASE), 64'(rd_ptr_n)));
                end else if (wr_valid) begin
                    state_n = WR_CMD;
                    write_n = 1'b1;
                    burst_n = BCW'(1);
                    addr_n  = AW'(fb_byte_addr(64'(BASE), 64'(wr_addr)));
                    wdata_n = wr_data;
                end
            end

            RD_CMD: begin
                if (!mem.mem_waitrequest) begin
                    read_n     = 1'b0;
                    rd_ptr_n   = (rd_ptr == IW'(NPIX - BURST)) ? '0 : rd_ptr + IW'(BURST);
                    beat_cnt_n = '0;
                    state_n    = RD_DATA;
                end
            end

            RD_DATA: begin
                // The burst always drains on the memory side; a set restart only suppresses forwarding.
                if (mem.mem_readdatavalid) begin
                    beat_cnt_n = beat_cnt + BCW'(1);
                    if (!restart) begin
                        pix_valid_n = 1'b1;
                        pix_data_n  = mem.mem_readdata;
                    end
                    if (beat_cnt == BCW'(BURST - 1)) begin
                        state_n = IDLE;
                    end
                end
            end

            WR_CMD: begin
                if (!mem.mem_waitrequest) begin
                    write_n    = 1'b0;
                    wr_ready_n = 1'b1;
                    state_n    = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter on a reduced 64x32 frame so a full frame wrap fits in a short run.
module tb_fb_arbiter;
    import fb_pkg::*;

    localparam int HDISP = 64;
    localparam int VDISP = 32;
    localparam int BURST = 16;
    localparam int NPIX  = HDISP * VDISP;
    localparam int IW    = $clog2(NPIX);

    logic            pixel_clk;
    logic            pixel_rst;
    logic            frame_start;
    logic            fifo_low;
    logic [31:0]     pix_data;
    logic            pix_valid;
    logic            wr_valid;
    logic [IW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic            wr_ready;
    fb_state_t       dbg_state;

    fb_arbiter_if #(.AW(32), .BCW(5)) mem ();

    fb_arbiter #(
        .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .AW(32), .BASE(32'h0)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .frame_start (frame_start),
        .fifo_low    (fifo_low),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .dbg_state   (dbg_state),
        .mem         (mem.master)
    );

    // ---------------- clock ----------------
    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [31:0] mem_word(input int w);
        return {8'h5A, 24'(w * 7 + 3)};
    endfunction

    // Model state: a frame_start bumps the epoch; a burst is tagged with the epoch in force
    // when it was issued. Its beats reach the FIFO only while that epoch is still current,
    // and a burst whose epoch differs from the previous one starts again at pixel 0.
    int epoch = 0;
    int ep_prev_start = 0;
    bit prev_read = 0;
    bit have_prev = 0;
    int last_stamp = 0;
    int last_idx = 0;
    int cmd_idx = 0;
    int cmd_stamp = 0;
    int cd = 0;
    int beats_left = 0;
    int beats_sent = 0;
    int beat_word = 0;
    int beat_stamp = -1;
    int burst_base = -1;
    int accept_count = 0;
    int acc_addr = 0;
    int burst_pix = 0;
    int last_burst_pix = 0;
    int wr_ready_count = 0;

    // ---------------- memory model + scoreboard, once per cycle after the falling edge ----------------
    initial begin
        int ep_start;
        logic [31:0] e;
        mem.mem_readdatavalid = 1'b0;
        mem.mem_readdata = '0;
        forever begin
            @(negedge pixel_clk);
            #1;
            ep_start = epoch;

            // compare outputs produced by the last rising edge
            if (pixel_rst) exp_q.delete();
            chk("pix_valid", pix_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (pix_valid) chk("pix_data", pix_data, e);
            end
            if (pix_valid) burst_pix++;
            if (wr_ready) wr_ready_count++;

            if (pixel_rst) begin
                have_prev = 0;
                beat_stamp = -1;
            end

            // new read command seen: it was issued on the previous edge
            if (mem.mem_read && !prev_read) begin
                cmd_stamp = ep_prev_start;
                if (!have_prev || cmd_stamp != last_stamp) cmd_idx = 0;
                else cmd_idx = (last_idx == NPIX - BURST) ? 0 : last_idx + BURST;
                have_prev = 1;
                last_stamp = cmd_stamp;
                last_idx = cmd_idx;
            end
            if (mem.mem_read) begin
                chk("cmd_address", mem.mem_address, 64'(4 * cmd_idx));
                chk("cmd_burstcount", mem.mem_burstcount, 64'(BURST));
            end
            prev_read = mem.mem_read;

            // read data phase for the coming edge
            mem.mem_readdatavalid = 1'b0;
            if (cd > 0) cd--;
            if (cd == 0 && beats_left > 0) begin
                mem.mem_readdatavalid = 1'b1;
                mem.mem_readdata = mem_word(beat_word);
                if (!pixel_rst && beat_stamp == ep_start) exp_q.push_back(mem_word(beat_word));
                beat_word++;
                beats_left--;
                beats_sent++;
            end

            // command accepted on the coming edge; data starts three cycles later
            if (mem.mem_read && !mem.mem_waitrequest && !pixel_rst) begin
                cd = 3;
                beats_left = BURST;
                beats_sent = 0;
                beat_word = int'(mem.mem_address >> 2);
                burst_base = beat_word;
                beat_stamp = cmd_stamp;
                acc_addr = int'(mem.mem_address);
                last_burst_pix = burst_pix;
                burst_pix = 0;
                accept_count++;
            end

            if (frame_start) epoch++;
            ep_prev_start = ep_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input string name);
        int n0;
        bit got;
        n0 = accept_count;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge pixel_clk);
            if (accept_count != n0) got = 1;
        end
        if (!got) expire(name);
    endtask

    task automatic wait_beat(input string name, input int base, input int n);
        bit got;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge pixel_clk);
            if ((base < 0 || burst_base == base) && beats_sent == n && beats_left == BURST - n) got = 1;
        end
        if (!got) expire(name);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_mem_read"}, mem.mem_read, 0);
        chk({tag, "_mem_write"}, mem.mem_write, 0);
        chk({tag, "_mem_address"}, mem.mem_address, 0);
        chk({tag, "_mem_burstcount"}, mem.mem_burstcount, 0);
        chk({tag, "_mem_writedata"}, mem.mem_writedata, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n0;
        bit got;
        pixel_rst = 1'b1;
        frame_start = 1'b0;
        fifo_low = 1'b0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        mem.mem_waitrequest = 1'b0;

        repeat (3) @(negedge pixel_clk);
        check_all_zero("reset");

        // continuous display fetch: bursts at 0x0, 0x40, 0x80
        pixel_rst = 1'b0;
        fifo_low = 1'b1;
        @(negedge pixel_clk);
        chk("first_read_cmd", mem.mem_read, 1);
        chk("first_read_addr", mem.mem_address, 32'h0);
        chk("first_read_burst", mem.mem_burstcount, 16);
        wait_accept("burst0");
        chk("burst0_addr", acc_addr, 32'h0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pixel_clk);
            if (pix_valid) got = 1;
        end
        if (!got) expire("first_pixel");
        else chk("first_pixel_data", pix_data, 32'h5A00_0003);
        wait_accept("burst1");
        chk("burst1_addr", acc_addr, 32'h40);
        chk("burst0_pix_count", last_burst_pix, 16);
        wait_accept("burst2");
        chk("burst2_addr", acc_addr, 32'h80);
        chk("burst1_pix_count", last_burst_pix, 16);

        // run through the rest of the frame: last burst at 2032, then wrap to 0
        for (int b = 3; b < NPIX / BURST; b++) wait_accept("frame_run");
        chk("last_burst_addr", acc_addr, 32'h1FC0);
        wait_accept("wrap");
        chk("wrap_addr", acc_addr, 32'h0);

        // frame_start coinciding with beat 5 of the burst from index 160
        wait_beat("burst160_beat4", 160, 4);
        frame_start = 1'b1;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        wait_accept("after_restart");
        chk("restart_addr", acc_addr, 32'h0);
        chk("restart_pix_count", last_burst_pix, 5);

        // host write with waitrequest stalling it for four cycles
        fifo_low = 1'b0;
        repeat (30) @(negedge pixel_clk);
        chk("quiet_read", mem.mem_read, 0);
        n0 = wr_ready_count;
        wr_valid = 1'b1;
        wr_addr = IW'(1000);
        wr_data = 32'h0000_FF00;
        mem.mem_waitrequest = 1'b1;
        @(negedge pixel_clk);
        chk("wr_cmd", mem.mem_write, 1);
        chk("wr_addr", mem.mem_address, 32'hFA0);
        chk("wr_data", mem.mem_writedata, 32'h0000_FF00);
        chk("wr_burst", mem.mem_burstcount, 1);
        chk("wr_no_read", mem.mem_read, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pixel_clk);
            chk("wr_hold_cmd", mem.mem_write, 1);
            chk("wr_hold_addr", mem.mem_address, 32'hFA0);
            chk("wr_hold_ready", wr_ready, 0);
        end
        mem.mem_waitrequest = 1'b0;
        @(negedge pixel_clk);
        chk("wr_ready_pulse", wr_ready, 1);
        chk("wr_cmd_drop", mem.mem_write, 0);
        wr_valid = 1'b0;
        @(negedge pixel_clk);
        chk("wr_ready_low", wr_ready, 0);
        repeat (3) @(negedge pixel_clk);
        chk("wr_ready_count", wr_ready_count - n0, 1);

        // read and write requested together: the read goes first
        fifo_low = 1'b1;
        wr_valid = 1'b1;
        wr_addr = IW'(5);
        wr_data = 32'h0012_3456;
        @(negedge pixel_clk);
        chk("prio_read", mem.mem_read, 1);
        chk("prio_no_write", mem.mem_write, 0);
        wait_accept("prio_burst");
        fifo_low = 1'b0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pixel_clk);
            if (mem.mem_write) got = 1;
        end
        if (!got) expire("prio_write");
        else begin
            chk("prio_burst_done", burst_pix, 16);
            chk("prio_wr_addr", mem.mem_address, 32'h14);
            chk("prio_wr_data", mem.mem_writedata, 32'h0012_3456);
        end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge pixel_clk);
            if (wr_ready) got = 1;
        end
        if (!got) expire("prio_wr_ready");
        wr_valid = 1'b0;
        repeat (3) @(negedge pixel_clk);

        // reset in the middle of a burst
        fifo_low = 1'b1;
        wait_accept("rst_burst");
        wait_beat("rst_beat3", -1, 3);
        fifo_low = 1'b0;
        pixel_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge pixel_clk);
        pixel_rst = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge pixel_clk);
            if (beats_left == 0) got = 1;
        end
        if (!got) expire("rst_drain");
        repeat (2) @(negedge pixel_clk);
        chk("rst_idle_read", mem.mem_read, 0);
        fifo_low = 1'b1;
        @(negedge pixel_clk);
        chk("post_rst_read", mem.mem_read, 1);
        chk("post_rst_addr", mem.mem_address, 32'h0);
        wait_accept("post_rst_burst");
        repeat (25) @(negedge pixel_clk);
        fifo_low = 1'b0;
        repeat (3) @(negedge pixel_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
